// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg: sequencer states plus the array instruction and dataflow mode encodings
package mac_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, LOAD_W, GAP, EXEC, DRAIN, NEXT, DONE} state_t;
   localparam logic [1:0] INST_IDLE = 2'b00;
   localparam logic [1:0] INST_LOAD = 2'b01;
   localparam logic [1:0] INST_EXEC = 2'b10;
   localparam logic MODE_WS = 1'b0;
   localparam logic MODE_OS = 1'b1;
endpackage

// File: rtl/mac_ctrl_addr_gen.sv
// mac_ctrl_addr_gen: registers the SRAM read request and delays inst_w to meet the read data
module mac_ctrl_addr_gen import mac_ctrl_pkg::*; #(
   parameter int addr_bw = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ld,
   input  logic [addr_bw-1:0] base,
   input  logic [addr_bw-1:0] idx,
   input  logic [1:0]         inst,
   output logic               rd_en,
   output logic [addr_bw-1:0] rd_addr,
   output logic [1:0]         inst_w
);
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_en <= 1'b0;
         rd_addr <= '0;
         inst_w <= INST_IDLE;
      end else begin
         rd_en <= ld;
         rd_addr <= ld ? base + idx : rd_addr;
         inst_w <= inst;
      end
   end
endmodule

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: per-kij scheduler of weight load, activation stream and drain for the 8x8 MAC array
module mac_array_ctrl import mac_ctrl_pkg::*; #(
   parameter int row = 8,
   parameter int col = 8,
   parameter int addr_bw = 11,
   parameter int kij_bw = 4,
   parameter int nij_bw = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               mode,
   input  logic [kij_bw-1:0]  num_kij,
   input  logic [nij_bw-1:0]  num_nij,
   input  logic [addr_bw-1:0] w_base,
   input  logic [addr_bw-1:0] x_base,
   input  logic [col-1:0]     valid,
   output logic               rd_en,
   output logic [addr_bw-1:0] rd_addr,
   output logic [1:0]         inst_w,
   output logic               sel_mode,
   output logic               ofifo_wr,
   output logic               busy,
   output logic               done,
   output logic               err
);
   localparam int cw = $clog2(col);
   localparam int dw = $clog2(2 * (row + col) + (1 << nij_bw));
   state_t state;
   logic [cw-1:0] i;
   logic [nij_bw-1:0] j, vcnt, nnij;
   logic [kij_bw-1:0] kij, nkij;
   logic [addr_bw-1:0] wb, xb, wk, base, idx;
   logic [dw-1:0] dcnt;
   logic [1:0] inst;
   logic cfg_bad, go, more, ld_w, ld_x, wd, d_end, unused_valid;
   assign unused_valid = ^valid[col-2:0];
   assign busy = state != IDLE;
   assign ofifo_wr = busy & valid[col-1];
   assign cfg_bad = num_kij == '0 || num_nij == '0;
   assign go = state == IDLE && start && !cfg_bad;
   assign more = state == NEXT && kij != nkij;
   assign wk = wb + addr_bw'(kij) * addr_bw'(col);
   // The request below describes next cycle's read, so the registered address lines up with the state.
   assign ld_w = (go && mode == MODE_WS) || (state == LOAD_W && i != cw'(col - 1)) || (more && sel_mode == MODE_WS);
   assign ld_x = (go && mode == MODE_OS) || state == GAP || (state == EXEC && j != nnij - 1'b1) || (more && sel_mode == MODE_OS);
   assign idx = state == LOAD_W ? addr_bw'(i) + 1'b1 : state == EXEC ? addr_bw'(j) + 1'b1 : '0;
   assign base = ld_w ? (state == IDLE ? w_base : wk) : (state == IDLE ? x_base : xb);
   assign inst = state == LOAD_W ? INST_LOAD : state == EXEC ? INST_EXEC : (state == DRAIN && sel_mode == MODE_OS) ? INST_LOAD : INST_IDLE;
   assign wd = dcnt == dw'(2 * (row + col)) + dw'(nnij) - 1'b1;
   assign d_end = sel_mode == MODE_OS ? (vcnt == nij_bw'(row) || dcnt == dw'(row + col - 1)) : vcnt == nnij;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         {i, j, kij, vcnt, dcnt} <= '0;
         {nkij, nnij, wb, xb} <= '0;
         sel_mode <= MODE_WS;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         done <= state == DONE;
         vcnt <= busy && valid[col-1] ? vcnt + 1'b1 : vcnt;
         case (state)
            IDLE: if (start) begin
               {nkij, nnij, wb, xb, sel_mode} <= {num_kij, num_nij, w_base, x_base, mode};
               err <= cfg_bad;
               {i, j, kij, vcnt} <= '0;
               state <= cfg_bad ? DONE : mode == MODE_OS ? EXEC : LOAD_W;
            end
            LOAD_W: begin
               i <= i + 1'b1;
               state <= i == cw'(col - 1) ? GAP : LOAD_W;
            end
            GAP: begin
               j <= '0;
               state <= EXEC;
            end
            EXEC: begin
               j <= j + 1'b1;
               dcnt <= '0;
               state <= j == nnij - 1'b1 ? DRAIN : EXEC;
            end
            DRAIN: begin
               dcnt <= dcnt + 1'b1;
               err <= err | (wd && !d_end);
               if (d_end || wd) begin
                  kij <= kij + 1'b1;
                  vcnt <= '0;
                  state <= NEXT;
               end
            end
            NEXT: begin
               i <= '0;
               j <= '0;
               state <= kij == nkij ? DONE : sel_mode == MODE_OS ? EXEC : LOAD_W;
            end
            default: state <= IDLE;
         endcase
      end
   end
   mac_ctrl_addr_gen #(.addr_bw(addr_bw)) u_addr_gen (
      .clk(clk),
      .reset(reset),
      .ld(ld_w | ld_x),
      .base(base),
      .idx(idx),
      .inst(inst),
      .rd_en(rd_en),
      .rd_addr(rd_addr),
      .inst_w(inst_w)
   );
endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb_mac_array_ctrl: table-driven and randomized tiles checked against a phase-level schedule model
module tb_mac_array_ctrl;
   import mac_ctrl_pkg::*;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0;
   logic [3:0] num_kij = '0;
   logic [5:0] num_nij = '0;
   logic [10:0] w_base = '0, x_base = '0;
   logic [7:0] valid = '0;
   logic rd_en, sel_mode, ofifo_wr, busy, done, err;
   logic [10:0] rd_addr;
   logic [1:0] inst_w;
   int tests = 0, fails = 0;

   typedef struct {logic m; int k; int n; int wb; int xb; bit drv; bit wd; bit e_err; int e_wr;} vec_t;
   typedef struct {logic [10:0] a; logic [1:0] ins;} rd_t;
   typedef struct {logic [1:0] v; int len;} run_t;

   always #5 clk = ~clk;

   mac_array_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .num_kij(num_kij), .num_nij(num_nij),
      .w_base(w_base), .x_base(x_base), .valid(valid), .rd_en(rd_en), .rd_addr(rd_addr),
      .inst_w(inst_w), .sel_mode(sel_mode), .ofifo_wr(ofifo_wr), .busy(busy), .done(done), .err(err)
   );

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_inst_w"}, inst_w, 0);
      chk({tag, "_sel_mode"}, sel_mode, 0);
      chk({tag, "_ofifo_wr"}, ofifo_wr, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   task automatic run_tile(input vec_t v);
      rd_t eq[$];
      run_t er[$], ob[$];
      rd_t r;
      logic [1:0] pend, cur;
      int len, vleft, since, cyc, wr, dones, done_cyc, wlen;
      bit sel_ok, zero;
      pend = 0; cur = 0; len = 0; vleft = 0; since = -1; cyc = 0; wr = 0; dones = 0; done_cyc = -1;
      sel_ok = 1;
      zero = v.k == 0 || v.n == 0;
      wlen = 2 * 16 + v.n;
      if (!zero) for (int k = 0; k < v.k; k++) begin
         if (!v.m) begin
            for (int i = 0; i < 8; i++) eq.push_back('{11'((v.wb + k * 8 + i) % 2048), INST_LOAD});
            er.push_back('{INST_LOAD, 8});
         end
         for (int j = 0; j < v.n; j++) eq.push_back('{11'((v.xb + j) % 2048), INST_EXEC});
         er.push_back('{INST_EXEC, v.n});
         if (v.m) er.push_back('{INST_LOAD, 16});
      end
      tick();
      mode = v.m; num_kij = 4'(v.k); num_nij = 6'(v.n); w_base = 11'(v.wb); x_base = 11'(v.xb);
      start = 1;
      tick();
      start = 0;
      while (cyc < 3000) begin
         cyc++;
         if (since >= 0) since++;
         if (cyc == 1) begin
            chk("first_rd_en", rd_en, !zero);
            chk("busy_after_start", busy, 1);
            chk("err_at_start", err, zero);
         end
         if (pend != 0) chk("inst_align", inst_w, pend);
         pend = 0;
         if (rd_en) begin
            if (eq.size() == 0) begin
               tests++; fails++;
               $display("FAIL extra_read: rd_addr %0d with no read expected", rd_addr);
            end else begin
               r = eq.pop_front();
               chk("rd_addr", rd_addr, r.a);
               pend = r.ins;
            end
         end
         if (inst_w == cur) len++;
         else begin
            if (cur != 0) ob.push_back('{cur, len});
            if (cur == INST_EXEC) begin
               since = 0;
               vleft = v.drv ? v.n : 0;
            end
            cur = inst_w;
            len = 1;
         end
         if (v.wd && since == wlen - 3) chk("watchdog_not_early", err, 0);
         if (busy && sel_mode != v.m) sel_ok = 0;
         if (ofifo_wr) wr++;
         if (done) begin
            chk("busy_low_at_done", busy, 0);
            dones++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
         valid[6:0] = 7'($urandom);
         valid[7] = vleft > 0 && $urandom_range(0, 2) != 0;
         if (valid[7]) vleft--;
         start = v.wd && cyc == 20;
         if (start) begin
            mode = ~v.m; num_nij = 6'd7; w_base = 11'd999; x_base = 11'd777;
         end
         tick();
      end
      valid = '0;
      start = 0;
      if (cur != 0) ob.push_back('{cur, len});
      if (done_cyc < 0) begin
         tests++; fails++;
         $display("FAIL done_timeout: no done within %0d cycles", cyc);
      end
      chk("done_pulses", dones, 1);
      if (zero) chk("done_latency", done_cyc, 2);
      chk("reads_missing", eq.size(), 0);
      chk("run_count", ob.size(), er.size());
      for (int q = 0; q < ob.size() && q < er.size(); q++) begin
         chk("run_kind", ob[q].v, er[q].v);
         chk("run_len", ob[q].len, er[q].len);
      end
      chk("err_final", err, v.e_err);
      chk("ofifo_wr_count", wr, v.e_wr);
      chk("sel_mode_held", sel_ok, 1);
   endtask

   initial begin
      vec_t tbl[8];
      vec_t rv;
      int n;
      tbl[0] = '{1'b0, 1, 4, 0, 100, 1'b1, 1'b0, 1'b0, 4};
      tbl[1] = '{1'b0, 3, 2, 16, 200, 1'b1, 1'b0, 1'b0, 6};
      tbl[2] = '{1'b1, 2, 5, 9, 300, 1'b0, 1'b0, 1'b0, 0};
      tbl[3] = '{1'b0, 2, 0, 4, 60, 1'b1, 1'b0, 1'b1, 0};
      tbl[4] = '{1'b0, 1, 3, 2044, 2046, 1'b1, 1'b0, 1'b0, 3};
      tbl[5] = '{1'b0, 1, 3, 8, 50, 1'b0, 1'b1, 1'b1, 0};
      tbl[6] = '{1'b1, 0, 3, 0, 10, 1'b0, 1'b0, 1'b1, 0};
      tbl[7] = '{1'b1, 1, 8, 0, 2044, 1'b0, 1'b0, 1'b0, 0};
      valid = 8'hff;
      repeat (3) tick();
      check_reset_outputs("reset");
      valid = '0;
      reset = 0;
      foreach (tbl[t]) run_tile(tbl[t]);
      tick();
      mode = 0; num_kij = 4'd2; num_nij = 6'd10; w_base = 11'd5; x_base = 11'd40;
      start = 1;
      tick();
      start = 0;
      n = 0;
      while (inst_w != INST_EXEC && n < 50) begin
         tick();
         n++;
      end
      chk("reached_exec", inst_w, INST_EXEC);
      valid = 8'hff;
      reset = 1;
      tick();
      check_reset_outputs("mid_exec_reset");
      reset = 0;
      valid = '0;
      run_tile(tbl[1]);
      for (int t = 0; t < 10; t++) begin
         rv.m = 1'($urandom_range(0, 1));
         rv.k = $urandom_range(1, 4);
         rv.n = $urandom_range(1, 12);
         rv.wb = $urandom_range(0, 2047);
         rv.xb = $urandom_range(0, 2047);
         rv.drv = !rv.m;
         rv.wd = 0;
         rv.e_err = 0;
         rv.e_wr = rv.m ? 0 : rv.k * rv.n;
         run_tile(rv);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
